// File: rtl/serial_alu_seq_if.sv
// Handshake and operand/result bundle between the control FSM and the
// digit-serial ALU sequencer.
interface serial_alu_seq_if #(
  parameter int XLEN = 32
);
  localparam int BW = $clog2(XLEN) + 1;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [BW-1:0]   b_bits;
  logic            b_signed;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            carry_out;
  logic            zero;

  // Requester side: issues operations and watches busy/done.
  modport master (
    output start, op, a, b, b_bits, b_signed,
    input  busy, done, result, carry_out, zero
  );

  // ALU side: accepts operations and returns the result.
  modport slave (
    input  start, op, a, b, b_bits, b_signed,
    output busy, done, result, carry_out, zero
  );
endinterface

// File: rtl/serial_alu_seq.sv
// Digit-serial ALU sequencer: one DIGIT_W slice per clock, LSB first, with
// operand-B width/sign extension and early termination for ADD.
module serial_alu_seq #(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_alu_seq_if.slave  io_bus
);
  localparam int NDIG = XLEN / DIGIT_W;
  localparam int BW   = $clog2(XLEN) + 1;
  localparam int LW   = $clog2(XLEN);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  generate
    if (XLEN % DIGIT_W != 0) begin : g_bad_digit_w
      $error("serial_alu_seq: DIGIT_W must divide XLEN");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_a, r_b, r_acc, r_result;
  logic [2:0]        r_op;
  logic              r_carry, r_carry_out, r_zero;
  logic [IW-1:0]     r_idx;

  logic              w_accept, w_last, w_early, w_finish, w_b_hi_zero, w_arith;
  logic [BW-1:0]     w_nb;
  logic [LW-1:0]     w_msb;
  logic              w_sext;
  logic [XLEN-1:0]   w_b_ext, w_final;
  logic [DIGIT_W-1:0] w_da, w_db, w_digit;
  logic [DIGIT_W:0]  w_sum;
  logic              w_carry_nxt;

  // Extend raw b to XLEN bits from its b_bits valid LSBs (0 or oversize = full width).
  always_comb begin
    w_nb = io_bus.b_bits;
    if (io_bus.b_bits == '0 || io_bus.b_bits > BW'(XLEN)) w_nb = BW'(XLEN);
    w_msb   = LW'(w_nb - 1'b1);
    w_sext  = io_bus.b_signed & io_bus.b[w_msb];
    w_b_ext = '0;
    for (int i = 0; i < XLEN; i++)
      w_b_ext[i] = (BW'(i) < w_nb) ? io_bus.b[i] : w_sext;
  end

  // Current digit: operand slices, per-op digit result and next carry.
  always_comb begin
    w_da        = DIGIT_W'(r_a >> (int'(r_idx) * DIGIT_W));
    w_db        = DIGIT_W'(r_b >> (int'(r_idx) * DIGIT_W));
    w_sum       = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT_W{1'b0}}, r_carry};
    w_digit     = '0;
    w_carry_nxt = r_carry;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_digit     = w_sum[DIGIT_W-1:0];
        w_carry_nxt = w_sum[DIGIT_W];
      end
      OP_AND:  w_digit = w_da & w_db;
      OP_OR:   w_digit = w_da | w_db;
      OP_XOR:  w_digit = w_da ^ w_db;
      default: w_digit = '0;
    endcase
  end

  // Completion detection and the result as it would stand after this digit;
  // digits above idx come from a, which is only kept on an early ADD exit.
  always_comb begin
    w_arith     = (r_op == OP_ADD) || (r_op == OP_SUB);
    w_last      = (r_idx == IW'(NDIG - 1));
    w_b_hi_zero = ((r_b >> ((int'(r_idx) + 1) * DIGIT_W)) == '0);
    w_early     = (r_state == S_RUN) && (r_op == OP_ADD) && !w_last &&
                  !w_carry_nxt && w_b_hi_zero;
    w_finish    = (r_state == S_RUN) && (w_last || w_early);
    w_final     = '0;
    for (int j = 0; j < NDIG; j++) begin
      if (j < int'(r_idx))       w_final[j*DIGIT_W +: DIGIT_W] = r_acc[j*DIGIT_W +: DIGIT_W];
      else if (j == int'(r_idx)) w_final[j*DIGIT_W +: DIGIT_W] = w_digit;
      else                       w_final[j*DIGIT_W +: DIGIT_W] = r_a[j*DIGIT_W +: DIGIT_W];
    end
  end

  // Next-state logic; start is honoured only in IDLE or DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (io_bus.start) begin
        w_accept    = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN:  if (w_finish) w_state_nxt = S_DONE;
      S_DONE: begin
        if (io_bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand latch on accept, digit accumulation in RUN, outputs at completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_accept) begin
      r_a     <= io_bus.a;
      r_op    <= io_bus.op;
      r_b     <= (io_bus.op == OP_SUB) ? ~w_b_ext : w_b_ext;
      r_carry <= (io_bus.op == OP_SUB);
      r_idx   <= '0;
      r_acc   <= '0;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_final;
      r_carry <= w_carry_nxt;
      r_idx   <= r_idx + 1'b1;
      if (w_finish) begin
        r_result    <= w_final;
        r_carry_out <= w_arith ? w_carry_nxt : 1'b0;
        r_zero      <= (w_final == '0);
      end
    end
  end

  assign io_bus.busy      = (r_state == S_RUN);
  assign io_bus.done      = (r_state == S_DONE);
  assign io_bus.result    = r_result;
  assign io_bus.carry_out = r_carry_out;
  assign io_bus.zero      = r_zero;
endmodule
